// File: rtl/subtract_pkg.sv
// Shared constants and the per-stage pipeline record for the borrow-select subtractor.
package subtract_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;
  // Widest operand the stage record can carry; narrower instances use the low bits.
  localparam int SUB_MAX_W = 64;

  // One pipeline stage: valid, resolved low difference bits, operands still to be
  // resolved, pending borrow, operand sign bits and the overflow flag.
  typedef struct packed {
    logic                 vld;
    logic [SUB_MAX_W-1:0] diff;
    logic [SUB_MAX_W-1:0] rem_a;
    logic [SUB_MAX_W-1:0] rem_b;
    logic                 borrow;
    logic                 a_msb;
    logic                 b_msb;
    logic                 ovf;
  } stage_t;
endpackage

// File: rtl/borrow_select_slice.sv
// Combinational SLICE-bit borrow-select subtractor: both borrow-in outcomes are
// computed by ripple chains, and the real borrow picks one.
module borrow_select_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_bin,
  output logic [SLICE-1:0] o_d,
  output logic             o_bout
);
  logic [SLICE-1:0] w_d0, w_d1;
  logic             w_b0, w_b1;

  // Two ripple subtractors, borrow-in fixed at 0 and at 1.
  always_comb begin
    logic br0, br1;
    br0  = 1'b0;
    br1  = 1'b1;
    w_d0 = '0;
    w_d1 = '0;
    for (int i = 0; i < SLICE; i++) begin
      w_d0[i] = i_a[i] ^ i_b[i] ^ br0;
      w_d1[i] = i_a[i] ^ i_b[i] ^ br1;
      br0     = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & br0);
      br1     = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & br1);
    end
    w_b0 = br0;
    w_b1 = br1;
  end

  assign o_d    = i_bin ? w_d1 : w_d0;
  assign o_bout = i_bin ? w_b1 : w_b0;
endmodule

// File: rtl/pipelined_borrow_select_subtractor.sv
// Pipelined d = a - b - bin, one SLICE resolved per stage, valid/ready on both sides.
// Stage register k holds slices 0..k resolved; the last stage register is the output.
module pipelined_borrow_select_subtractor
  import subtract_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int SLICE  = DEF_SLICE,
  localparam int STAGES = WIDTH / SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);
  stage_t            r_stg [STAGES];
  logic [STAGES:0]   w_ready;

  // Ready chain: a stage accepts when empty or when its contents move downstream.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      w_ready[k] = ~r_stg[k].vld | w_ready[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           w_src, w_nxt;
    logic [SLICE-1:0] w_sd;
    logic             w_sb;

    if (k == 0) begin : g_head
      // Stage 0 takes operands straight from the input port.
      always_comb begin
        w_src                   = '0;
        w_src.vld               = in_valid;
        w_src.rem_a[WIDTH-1:0]  = a;
        w_src.rem_b[WIDTH-1:0]  = b;
        w_src.borrow            = bin;
        w_src.a_msb             = a[WIDTH-1];
        w_src.b_msb             = b[WIDTH-1];
      end
    end else begin : g_body
      assign w_src = r_stg[k-1];
    end

    borrow_select_slice #(.SLICE(SLICE)) u_slice (
      .i_a    (w_src.rem_a[k*SLICE +: SLICE]),
      .i_b    (w_src.rem_b[k*SLICE +: SLICE]),
      .i_bin  (w_src.borrow),
      .o_d    (w_sd),
      .o_bout (w_sb)
    );

    // Merge the resolved slice; ovf is only meaningful once the top slice is in.
    always_comb begin
      w_nxt                        = w_src;
      w_nxt.diff[k*SLICE +: SLICE] = w_sd;
      w_nxt.borrow                 = w_sb;
      w_nxt.ovf                    = (w_src.a_msb ^ w_src.b_msb) &
                                     (w_nxt.diff[WIDTH-1] ^ w_src.a_msb);
    end

    // Advance when ready; a bubble only clears valid so held data never glitches.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_stg[k] <= '0;
      else if (w_ready[k]) begin
        if (w_src.vld) r_stg[k]     <= w_nxt;
        else           r_stg[k].vld <= 1'b0;
      end
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_stg[STAGES-1].vld;
  assign d         = r_stg[STAGES-1].diff[WIDTH-1:0];
  assign bout      = r_stg[STAGES-1].borrow;
  assign ovf       = r_stg[STAGES-1].ovf;
endmodule

// File: tb/tb_pipelined_borrow_select_subtractor.sv
// Directed/table-driven bench for the 16-bit, 4-stage borrow-select subtractor.
module tb_pipelined_borrow_select_subtractor;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] a = '0, b = '0, d;
  logic        bin = 1'b0;
  logic        out_valid, out_ready = 1'b1, bout, ovf;

  int   n_pass = 0, n_tot = 0;
  int   n_acc, n_out;
  vec_t pend[$];
  vec_t exq[$];
  vec_t tbl[10];

  pipelined_borrow_select_subtractor #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t model(input vec_t v);
    logic [16:0] full;
    vec_t r;
    r      = v;
    full   = {1'b0, v.a} - {1'b0, v.b} - {16'd0, v.bin};
    r.d    = full[15:0];
    r.bout = full[16];
    r.ovf  = (v.a[15] != v.b[15]) && (full[15] != v.a[15]);
    return r;
  endfunction

  // One clock of scoreboarded traffic: drive at negedge, observe handshakes 1ns later.
  task automatic step(input logic rdy);
    vec_t e;
    @(negedge clk);
    out_ready = rdy;
    if (pend.size() > 0) begin
      in_valid = 1'b1; a = pend[0].a; b = pend[0].b; bin = pend[0].bin;
    end else in_valid = 1'b0;
    #1;
    if (out_valid && out_ready) begin
      n_out++;
      if (exq.size() == 0) chk("spurious_result", 32'd1, 32'd0);
      else begin
        e = exq.pop_front();
        chk("stream_d", {16'd0, d}, {16'd0, e.d});
        chk("stream_flags", {30'd0, bout, ovf}, {30'd0, e.bout, e.ovf});
      end
    end
    if (in_valid && in_ready) begin
      exq.push_back(model(pend.pop_front()));
      n_acc++;
    end
  endtask

  // Isolated op on an empty pipe: checks exact latency, result and one-cycle valid.
  task automatic single(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    out_ready = 1'b1; a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1;
    #1 chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk({nm, "_latency"}, lat, 32'd4);
    chk({nm, "_d"}, {16'd0, d}, {16'd0, v.d});
    chk({nm, "_bout"}, {31'd0, bout}, {31'd0, v.bout});
    chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
    @(negedge clk);
    chk({nm, "_valid_one_cycle"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vec_t v, hold;
    int   steps;
    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tbl[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[5] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[7] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'h1E1F, 1'b1, 1'b0};
    tbl[8] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    tbl[9] = '{16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b1};

    // Reset is asserted from time 0, before any clock edge.
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outputs", {14'd0, d, bout, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_outputs", {14'd0, d, bout, ovf}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 10; i++) single(tbl[i], $sformatf("vec%0d", i));

    // Streaming: 200 back-to-back random ops at full throughput.
    for (int i = 0; i < 200; i++) begin
      v.a = 16'($urandom); v.b = 16'($urandom); v.bin = 1'($urandom);
      v.d = '0; v.bout = 1'b0; v.ovf = 1'b0;
      pend.push_back(v);
    end
    n_acc = 0; n_out = 0; steps = 0;
    while (n_out < 200 && steps < 400) begin step(1'b1); steps++; end
    chk("stream_count", n_out, 32'd200);
    chk("stream_cycles", steps, 32'd204);

    // Backpressure: with the consumer stalled only STAGES ops fit.
    for (int i = 0; i < 6; i++) begin
      v.a = 16'($urandom); v.b = 16'($urandom); v.bin = 1'($urandom);
      pend.push_back(v);
    end
    n_acc = 0; n_out = 0;
    for (int i = 0; i < 8; i++) step(1'b0);
    chk("bp_accepted", n_acc, 32'd4);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    hold.d = d; hold.bout = bout; hold.ovf = ovf;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", {14'd0, d, bout, ovf}, {14'd0, hold.d, hold.bout, hold.ovf});
    end
    steps = 0;
    while ((pend.size() > 0 || exq.size() > 0) && steps < 300) begin
      step(1'($urandom_range(0, 1))); steps++;
    end
    chk("bp_all_out", n_out, 32'd6);
    chk("bp_drained", exq.size() + pend.size(), 32'd0);

    // Reset mid-stream with 3 ops in flight and one sitting at the output.
    for (int i = 0; i < 3; i++) begin
      v.a = 16'h4000 + 16'(i); v.b = 16'h0001; v.bin = 1'b0;
      pend.push_back(v);
    end
    n_acc = 0;
    for (int i = 0; i < 6; i++) step(1'b0);
    chk("mid_rst_inflight", n_acc, 32'd3);
    chk("mid_rst_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_outputs", {14'd0, d, bout, ovf}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exq.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    n_out = 0;
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("mid_rst_no_ghosts", n_out, 32'd0);
    single(tbl[7], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
